// File: rtl/ddsm_pkg.sv
// ---------------------------------------------------------------------------
// ddsm_pkg
// Shared constants for the first-order delta-sigma sequence generator:
//   FRAC_W_DEF  : default fractional word / accumulator width
//   LFSR_W      : dither LFSR length (x^15 + x^14 + 1)
//   LFSR_TAP_*  : feedback tap bit positions (0-based)
//   LFSR_SEED   : LFSR reset value
//   lfsr_step() : one Fibonacci shift of the dither LFSR
// ---------------------------------------------------------------------------
package ddsm_pkg;

  localparam int FRAC_W_DEF = 4;

  localparam int LFSR_W      = 15;
  // x^15 and x^14 terms map to register bits 14 and 13
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

  // Shift left, feed the XOR of the two taps back into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/ddsm_lfsr.sv
// ---------------------------------------------------------------------------
// ddsm_lfsr
// 15-bit maximal-length Fibonacci LFSR providing a 1-bit dither stream for
// the delta-sigma accumulator. Advances every clock; reset loads the seed.
// Only built when the DDSM_DITHER_EN macro is defined; in the default build
// this file contributes no logic.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   dither : current dither bit (bit 0 of the LFSR)
// ---------------------------------------------------------------------------
`ifdef DDSM_DITHER_EN
module ddsm_lfsr
  import ddsm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic dither
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign dither = r_state[0];

endmodule
`endif

// File: rtl/ddsm_seq_gen.sv
// ---------------------------------------------------------------------------
// ddsm_seq_gen
// First-order digital delta-sigma modulator for the fractional-N divider.
// Every clock alpha_frac is added to a modulo-2^FRAC_W phase accumulator and
// the carry out is registered onto seq_out, so the density of ones equals
// alpha_frac / 2^FRAC_W.
// Configuration macro: DDSM_DITHER_EN -- widens the accumulator by one LSB
// and feeds an LFSR dither bit into it to break idle tones.
// Ports:
//   clk        : divider reference clock, rising edge
//   rst_n      : asynchronous active-low reset (clears phase and output)
//   alpha_frac : unsigned fractional word, sampled every rising edge
//   seq_out    : registered carry, one bit per clock
// ---------------------------------------------------------------------------
module ddsm_seq_gen
  import ddsm_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FRAC_W-1:0] alpha_frac,
  output logic              seq_out
);

`ifdef DDSM_DITHER_EN
  // Dither occupies a new LSB below alpha_frac, so the carry still comes out
  // at the same weight as in the plain accumulator.
  localparam int ACC_W = FRAC_W + 1;

  logic             w_dither;
  logic [ACC_W-1:0] w_addend;

  ddsm_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .dither (w_dither)
  );

  assign w_addend = {alpha_frac, w_dither};
`else
  localparam int ACC_W = FRAC_W;

  logic [ACC_W-1:0] w_addend;

  assign w_addend = alpha_frac;
`endif

  logic [ACC_W-1:0] r_acc;
  logic             r_seq;
  logic [ACC_W:0]   w_sum;

  // One bit wider than the accumulator so the MSB is the carry.
  assign w_sum = {1'b0, r_acc} + {1'b0, w_addend};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_seq <= 1'b0;
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
      r_seq <= w_sum[ACC_W];
    end
  end

  assign seq_out = r_seq;

endmodule

// File: tb/tb_ddsm_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_ddsm_seq_gen
// Self-checking bench for ddsm_seq_gen (FRAC_W = 4). The reference model
// tracks the unbounded running sum S of all addends since reset; the carry
// at an edge is floor(S_new/16) - floor(S_old/16).
// ---------------------------------------------------------------------------
module tb_ddsm_seq_gen;

  localparam int FW  = 4;
  localparam int MOD = 1 << FW;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] alpha_frac;
  logic          seq_out;

  int n_vec = 0;
  int n_bad = 0;

  ddsm_seq_gen #(.FRAC_W(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alpha_frac (alpha_frac),
    .seq_out    (seq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the bench only waits on the free-running clock, this is a backstop.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   alpha;
    int   edge_n;
    logic exp_seq;
  } vec_t;

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: seq_out=%b expected=%b", name, got, exp);
    end else begin
      $display("ok   %s: seq_out=%b", name, got);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  function automatic logic ref_carry(input longint s_old, input int a);
    return ((s_old + a) / MOD) != (s_old / MOD);
  endfunction

  // One-cycle reset pulse; edge 1 is the first posedge after release.
  task automatic pulse_reset(input int a);
    @(negedge clk);
    rst_n      = 1'b0;
    alpha_frac = a[FW-1:0];
    @(negedge clk);
    rst_n      = 1'b1;
  endtask

  initial begin
    vec_t   vecs[$];
    longint s;
    int     ones;
    int     a;

    rst_n      = 1'b0;
    alpha_frac = 4'd9;

`ifdef DDSM_DITHER_EN
    // Dither with alpha_frac = 0: expect about 4096/64 = 64 ones.
    pulse_reset(0);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (seq_out === 1'b1) ones++;
    end
    check_bit("dither_not_idle", ones > 0, 1'b1);
    check_bit("dither_density", (ones >= 51) && (ones <= 77), 1'b1);
    $display("dither ones over 4096 cycles: %0d", ones);
`else
    // Reset held with clock running.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("rst_hold", seq_out, 1'b0);
    end

    // Asynchronous reset while seq_out is 1 (alpha 9 carries at edge 2).
    pulse_reset(9);
    @(negedge clk);
    check_bit("a9_edge1", seq_out, 1'b0);
    @(negedge clk);
    check_bit("a9_edge2", seq_out, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_bit("async_rst", seq_out, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_bit("rst_hold2", seq_out, 1'b0);
    end
    rst_n = 1'b1;

    // Table of {alpha, edge after reset, expected seq_out}.
    vecs = '{
      '{1, 15, 1'b0}, '{1, 16, 1'b1}, '{1, 17, 1'b0}, '{1, 32, 1'b1},
      '{8, 1, 1'b0},  '{8, 2, 1'b1},  '{8, 3, 1'b0},  '{8, 4, 1'b1},
      '{15, 1, 1'b0}, '{15, 2, 1'b1}, '{15, 16, 1'b1}, '{15, 17, 1'b0},
      '{4, 3, 1'b0},  '{4, 4, 1'b1},  '{7, 2, 1'b0},  '{7, 3, 1'b1},
      '{3, 5, 1'b0},  '{3, 6, 1'b1},  '{0, 20, 1'b0}
    };
    foreach (vecs[i]) begin
      pulse_reset(vecs[i].alpha);
      for (int e = 0; e < vecs[i].edge_n; e++) @(negedge clk);
      check_bit($sformatf("tbl a=%0d edge=%0d", vecs[i].alpha, vecs[i].edge_n),
                seq_out, vecs[i].exp_seq);
    end

    // Sweep: 256 cycles yields exactly 16*alpha ones.
    for (int av = 1; av < MOD; av++) begin
      pulse_reset(av);
      ones = 0;
      for (int e = 0; e < 256; e++) begin
        @(negedge clk);
        if (seq_out === 1'b1) ones++;
      end
      check_int($sformatf("sweep a=%0d ones", av), ones, 16 * av);
    end

    // alpha 3 -> 5 without reset: phase carries over.
    pulse_reset(3);
    s = 0;
    for (int e = 0; e < 7; e++) begin
      @(negedge clk);
      check_bit("chg a=3", seq_out, ref_carry(s, 3));
      s += 3;
    end
    alpha_frac = 4'd5;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      check_bit("chg a=5", seq_out, ref_carry(s, 5));
      s += 5;
    end

    // Random alpha every cycle, with occasional asynchronous resets.
    pulse_reset(0);
    s = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_bit("rnd async_rst", seq_out, 1'b0);
        @(negedge clk);
        check_bit("rnd rst_hold", seq_out, 1'b0);
        rst_n = 1'b1;
        s = 0;
      end
      a = int'($urandom_range(0, MOD - 1));
      alpha_frac = a[FW-1:0];
      @(negedge clk);
      check_bit($sformatf("rnd a=%0d", a), seq_out, ref_carry(s, a));
      s += a;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
